// File: rtl/cachemem_assoc.sv
// N-way set-associative cache storage: tag, data and valid state per line,
// true-LRU ordering per set, write-allocate with victim reporting, and
// explicit line invalidation. Lookups are combinational; state updates on
// the rising clock edge.
module cachemem_assoc #(
   parameter int NUM_SETS = 32,
   parameter int NUM_WAYS = 4,
   parameter int TAG_W    = 24,
   parameter int DATA_W   = 64,
   localparam int IDX_W   = $clog2(NUM_SETS),
   localparam int WAY_W   = $clog2(NUM_WAYS)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rd1_en,
   input  logic [IDX_W-1:0]  rd1_idx,
   input  logic [TAG_W-1:0]  rd1_tag,
   output logic [DATA_W-1:0] rd1_data,
   output logic              rd1_valid,
   output logic [WAY_W-1:0]  rd1_way,
   input  logic              wr1_en,
   input  logic [IDX_W-1:0]  wr1_idx,
   input  logic [TAG_W-1:0]  wr1_tag,
   input  logic [DATA_W-1:0] wr1_data,
   output logic              wr1_evict_valid,
   output logic [TAG_W-1:0]  wr1_evict_tag,
   output logic [DATA_W-1:0] wr1_evict_data,
   input  logic              inv1_en,
   input  logic [IDX_W-1:0]  inv1_idx,
   input  logic [TAG_W-1:0]  inv1_tag
);

   // Per-line state. Tags and data carry no reset; valid bits gate them.
   logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
   logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
   logic [WAY_W-1:0]    age_q   [NUM_SETS][NUM_WAYS];
   logic [WAY_W-1:0]    age_d   [NUM_SETS][NUM_WAYS];
   logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
   logic [DATA_W-1:0]   data_q  [NUM_SETS][NUM_WAYS];

   logic [NUM_WAYS-1:0] rd_match;
   logic [NUM_WAYS-1:0] wr_match;
   logic [NUM_WAYS-1:0] wr_free;
   logic [NUM_WAYS-1:0] wr_lru;
   logic [NUM_WAYS-1:0] inv_match;

   logic                rd_hit;
   logic [WAY_W-1:0]    rd_way;
   logic                rd_touch;
   logic [WAY_W-1:0]    rd_age;
   logic [WAY_W-1:0]    wr_way;
   logic                wr_evict;
   logic [WAY_W-1:0]    wr_age;

   // Lowest set bit of a way vector; 0 when the vector is empty.
   function automatic logic [WAY_W-1:0] first_set(input logic [NUM_WAYS-1:0] v);
      first_set = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (v[w]) first_set = WAY_W'(w);
      end
   endfunction

   // Per-way tag comparators for the read, write and invalidate ports.
   for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way_cmp
      assign rd_match[gi]  = valid_q[rd1_idx][gi]  && (tag_q[rd1_idx][gi]  == rd1_tag);
      assign wr_match[gi]  = valid_q[wr1_idx][gi]  && (tag_q[wr1_idx][gi]  == wr1_tag);
      assign wr_free[gi]   = !valid_q[wr1_idx][gi];
      assign wr_lru[gi]    = (age_q[wr1_idx][gi] == WAY_W'(NUM_WAYS - 1));
      assign inv_match[gi] = valid_q[inv1_idx][gi] && (tag_q[inv1_idx][gi] == inv1_tag);
   end

   // Read lookup: lowest matching valid way wins if several match.
   always_comb begin
      rd_hit = |rd_match;
      rd_way = first_set(rd_match);
   end

   // Write target: in-place hit, else lowest invalid way, else the LRU victim.
   always_comb begin
      wr_way   = '0;
      wr_evict = 1'b0;
      if (|wr_match) begin
         wr_way = first_set(wr_match);
      end else if (|wr_free) begin
         wr_way = first_set(wr_free);
      end else begin
         wr_way   = first_set(wr_lru);
         wr_evict = 1'b1;
      end
   end

   assign rd1_valid       = rd_hit;
   assign rd1_way         = rd_way;
   assign rd1_data        = rd_hit ? data_q[rd1_idx][rd_way] : '0;
   assign wr1_evict_valid = wr1_en && wr_evict;
   assign wr1_evict_tag   = wr1_evict_valid ? tag_q[wr1_idx][wr_way]  : '0;
   assign wr1_evict_data  = wr1_evict_valid ? data_q[wr1_idx][wr_way] : '0;

   assign wr_age = age_q[wr1_idx][wr_way];
   assign rd_age = age_q[rd1_idx][rd_way];
   // A write touch in the same set takes precedence over the read touch.
   assign rd_touch = rd1_en && rd_hit && !(wr1_en && (wr1_idx == rd1_idx));

   // Next-state for valid bits and LRU ages; invalidate first so a
   // same-cycle write to the same line leaves it valid.
   always_comb begin
      valid_d = valid_q;
      age_d   = age_q;
      if (inv1_en) begin
         valid_d[inv1_idx] = valid_q[inv1_idx] & ~inv_match;
      end
      if (wr1_en) begin
         valid_d[wr1_idx][wr_way] = 1'b1;
         for (int w = 0; w < NUM_WAYS; w++) begin
            if (age_q[wr1_idx][w] < wr_age) age_d[wr1_idx][w] = age_q[wr1_idx][w] + 1'b1;
         end
         age_d[wr1_idx][wr_way] = '0;
      end
      if (rd_touch) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            if (age_q[rd1_idx][w] < rd_age) age_d[rd1_idx][w] = age_q[rd1_idx][w] + 1'b1;
         end
         age_d[rd1_idx][rd_way] = '0;
      end
   end

   // Valid/LRU state register; reset leaves way NUM_WAYS-1 as LRU.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_q[s] <= '0;
            for (int w = 0; w < NUM_WAYS; w++) begin
               age_q[s][w] <= WAY_W'(w);
            end
         end
      end else begin
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_q[s] <= valid_d[s];
            for (int w = 0; w < NUM_WAYS; w++) begin
               age_q[s][w] <= age_d[s][w];
            end
         end
      end
   end

   // Tag/data commit; a write during reset lands in a line left invalid,
   // so it stays invisible.
   always_ff @(posedge clock) begin
      if (wr1_en) begin
         tag_q[wr1_idx][wr_way]  <= wr1_tag;
         data_q[wr1_idx][wr_way] <= wr1_data;
      end
   end

endmodule
